// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and default widths for the ktc32 load/store unit.
package lsu_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ST_HI = 2'b01,
        RESP  = 2'b10
    } state_e;

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: selects the byte/halfword/word from the RAM read data and
// sign- or zero-extends it to the full core data width.
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    input  logic              sgn,
    output logic [DATA_W-1:0] ext
);

    // Extension by access size; reserved size yields zero
    always_comb begin
        ext = '0;
        case (size_e'(size))
            SZ_BYTE: ext = {{(DATA_W-8){sgn & data[7]}}, data[7:0]};
            SZ_HALF: ext = {{(DATA_W-16){sgn & data[15]}}, data[15:0]};
            SZ_WORD: ext = data;
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit in front of the byte-addressed data RAM.
// Word stores are split into two halfword writes (low half in IDLE, high half
// in ST_HI); byte stores merge with the neighbouring RAM byte.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned
// halfword/word accesses with resp_err instead of performing them.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W/2-1:0] ram_wd,
    input  logic [DATA_W-1:0]   ram_data
);

    localparam int unsigned HALF_W = DATA_W / 2;

    state_e              state;
    state_e              state_nx;
    size_e               req_sz;
    logic                accept;
    logic                misalign;
    logic                reject;
    logic [ADDR_W-1:0]   addr_q;
    logic [HALF_W-1:0]   wdata_hi_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   load_val;

    assign req_sz    = size_e'(req_size);
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_sz == SZ_HALF) && req_addr[0]) ||
                      ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign reject = (req_sz == SZ_RSVD) || misalign;

    lsu_load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .data (ram_data),
        .size (req_size),
        .sgn  (req_signed),
        .ext  (load_val)
    );

    assign resp_valid = (state == RESP) && !rst;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Next state and RAM port drive; reset overrides any write in flight
    always_comb begin
        state_nx = state;
        ram_we   = 1'b0;
        ram_addr = addr_q;
        ram_wd   = '0;
        case (state)
            IDLE: begin
                ram_addr = req_addr;
                if (req_sz == SZ_BYTE)
                    ram_wd = {ram_data[HALF_W-1:8], req_wdata[7:0]};
                else
                    ram_wd = req_wdata[HALF_W-1:0];
                if (accept) begin
                    ram_we = req_we && !reject;
                    if (req_we && !reject && (req_sz == SZ_WORD))
                        state_nx = ST_HI;
                    else
                        state_nx = RESP;
                end
            end
            ST_HI: begin
                ram_addr = addr_q + ADDR_W'(2);
                ram_wd   = wdata_hi_q;
                ram_we   = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (rst)
            ram_we = 1'b0;
    end

    // State register and request capture at the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_hi_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q     <= req_addr;
                wdata_hi_q <= req_wdata[DATA_W-1:HALF_W];
                err_q      <= reject;
                rdata_q    <= (req_we || reject) ? '0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu with a byte-addressed RAM model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wd;
    logic [31:0] ram_data;

    int n_cmp = 0;
    int n_bad = 0;

    // RAM model plus preload port
    logic [7:0]  mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [31:0] pl_word = '0;
    logic [15:0] ra1, ra2, ra3;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wd     (ram_wd),
        .ram_data   (ram_data)
    );

    always_comb begin
        ra1 = ram_addr + 16'd1;
        ra2 = ram_addr + 16'd2;
        ra3 = ram_addr + 16'd3;
        ram_data = {mem[ra3], mem[ra2], mem[ra1], mem[ram_addr]};
    end

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr]         <= pl_word[7:0];
            mem[pl_addr + 16'd1] <= pl_word[15:8];
            mem[pl_addr + 16'd2] <= pl_word[23:16];
            mem[pl_addr + 16'd3] <= pl_word[31:24];
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wd[7:0];
            mem[ra1]      <= ram_wd[15:8];
        end
    end

    function automatic logic [31:0] memw(input logic [15:0] a);
        return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
    endfunction

    task automatic preload(input logic [15:0] a, input logic [31:0] w);
        pl_en = 1'b1; pl_addr = a; pl_word = w;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [15:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 2'd1, 1'b0, 16'h0008, 32'h0000_1234);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", ram_we); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %b want 1", req_ready); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", resp_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_store;
        preload(16'h0010, 32'h4433_2211);
        drive(1'b1, 2'd0, 1'b0, 16'h0010, 32'h0000_00AB);
        @(negedge clk);
        n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL bs_we: got %b want 1", ram_we); end
        n_cmp++; if (ram_addr !== 16'h0010) begin n_bad++; $display("FAIL bs_addr: got %h want 0010", ram_addr); end
        n_cmp++; if (ram_wd !== 16'h22AB) begin n_bad++; $display("FAIL bs_wd: got %h want 22ab", ram_wd); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bs_resp: got %b want 1", resp_valid); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL bs_err: got %b want 0", resp_err); end
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL bs_resp_we: got %b want 0", ram_we); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bs_resp_ready: got %b want 0", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (memw(16'h0010) !== 32'h4433_22AB) begin n_bad++; $display("FAIL bs_mem: got %h want 443322ab", memw(16'h0010)); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL bs_single_pulse: got %b want 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bs_ready_again: got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_word_store;
        drive(1'b1, 2'd2, 1'b0, 16'h0020, 32'hDEAD_BEEF);
        @(negedge clk);
        n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL ws_lo_we: got %b want 1", ram_we); end
        n_cmp++; if (ram_addr !== 16'h0020) begin n_bad++; $display("FAIL ws_lo_addr: got %h want 0020", ram_addr); end
        n_cmp++; if (ram_wd !== 16'hBEEF) begin n_bad++; $display("FAIL ws_lo_wd: got %h want beef", ram_wd); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL ws_hi_we: got %b want 1", ram_we); end
        n_cmp++; if (ram_addr !== 16'h0022) begin n_bad++; $display("FAIL ws_hi_addr: got %h want 0022", ram_addr); end
        n_cmp++; if (ram_wd !== 16'hDEAD) begin n_bad++; $display("FAIL ws_hi_wd: got %h want dead", ram_wd); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL ws_early_resp: got %b want 0", resp_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL ws_resp: got %b want 1", resp_valid); end
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL ws_resp_we: got %b want 0", ram_we); end
        @(posedge clk); #1;
        drive(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL lw_resp: got %b want 1", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", resp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_ext;
        logic [1:0]  szs  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        sgs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FF80, 32'h0000_FF80};
        preload(16'h0030, 32'h0000_FF80);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, szs[i], sgs[i], 16'h0030, 32'h0);
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            n_cmp++; if (resp_rdata !== exps[i]) begin n_bad++; $display("FAIL ld_ext[%0d]: got %h want %h", i, resp_rdata, exps[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 2'd0, 1'b0, 16'h0030, 32'h0);
        @(posedge clk); #1;
        req_addr = 16'h0031;
        @(negedge clk);
        n_cmp++; if (resp_rdata !== 32'h0000_0080) begin n_bad++; $display("FAIL b2b_first: got %h want 00000080", resp_rdata); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: got %b want 0", req_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got %b want 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_second_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0000_00FF) begin n_bad++; $display("FAIL b2b_second: got %h want 000000ff", resp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_rsvd;
        drive(1'b1, 2'd2, 1'b0, 16'hFFFE, 32'h1234_ABCD);
        @(negedge clk);
        n_cmp++; if (ram_addr !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_lo_addr: got %h want fffe", ram_addr); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ram_addr !== 16'h0000) begin n_bad++; $display("FAIL wrap_hi_addr: got %h want 0000", ram_addr); end
        n_cmp++; if (ram_wd !== 16'h1234) begin n_bad++; $display("FAIL wrap_hi_wd: got %h want 1234", ram_wd); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_resp: got %b want 1", resp_valid); end
        @(posedge clk); #1;
        n_cmp++; if ({mem[16'h0001], mem[16'h0000], mem[16'hFFFF], mem[16'hFFFE]} !== 32'h1234_ABCD) begin
            n_bad++; $display("FAIL wrap_mem: got %h want 1234abcd", {mem[16'h0001], mem[16'h0000], mem[16'hFFFF], mem[16'hFFFE]}); end
        // load first so a stale nonzero result is visible if the error path keeps it
        drive(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 2'd3, 1'b1, 16'h0020, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp_err !== 1'b1) begin n_bad++; $display("FAIL rsvd_ld_err: got %b want 1", resp_err); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rsvd_ld_rdata: got %h want 0", resp_rdata); end
        @(posedge clk); #1;
        drive(1'b1, 2'd3, 1'b0, 16'h0010, 32'hFFFF_FFFF);
        @(negedge clk);
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rsvd_st_we: got %b want 0", ram_we); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL rsvd_st_resp: got %b want 1", resp_valid); end
        n_cmp++; if (resp_err !== 1'b1) begin n_bad++; $display("FAIL rsvd_st_err: got %b want 1", resp_err); end
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rsvd_st_resp_we: got %b want 0", ram_we); end
        @(posedge clk); #1;
        n_cmp++; if (memw(16'h0010) !== 32'h4433_22AB) begin n_bad++; $display("FAIL rsvd_st_mem: got %h want 443322ab", memw(16'h0010)); end
    endtask

    task automatic test_reset_mid;
        preload(16'h0050, 32'h0);
        drive(1'b1, 2'd2, 1'b0, 16'h0050, 32'h5566_7788);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rmid_we: got %b want 0", ram_we); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ready: got %b want 0", req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after: got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_resp: got %b want 0", resp_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_resp2: got %b want 0", resp_valid); end
        n_cmp++; if (memw(16'h0050) !== 32'h0000_7788) begin n_bad++; $display("FAIL rmid_mem: got %h want 00007788", memw(16'h0050)); end
        @(posedge clk); #1;
        drive(1'b0, 2'd0, 1'b0, 16'h0030, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rresp_valid: got %b want 0", resp_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rresp_after: got %b want 0", resp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign;
`ifdef LSU_MISALIGN_TRAP_EN
        logic        exp_we  = 1'b0;
        logic        exp_err = 1'b1;
        logic [31:0] exp_mem = 32'h0000_0000;
`else
        logic        exp_we  = 1'b1;
        logic        exp_err = 1'b0;
        logic [31:0] exp_mem = 32'h00CA_FE00;
`endif
        preload(16'h0040, 32'h0);
        drive(1'b1, 2'd1, 1'b0, 16'h0041, 32'h0000_CAFE);
        @(negedge clk);
        n_cmp++; if (ram_we !== exp_we) begin n_bad++; $display("FAIL mis_we: got %b want %b", ram_we, exp_we); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL mis_resp: got %b want 1", resp_valid); end
        n_cmp++; if (resp_err !== exp_err) begin n_bad++; $display("FAIL mis_err: got %b want %b", resp_err, exp_err); end
        @(posedge clk); #1;
        n_cmp++; if (memw(16'h0040) !== exp_mem) begin n_bad++; $display("FAIL mis_mem: got %h want %h", memw(16'h0040), exp_mem); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        test_reset();
        test_byte_store();
        test_word_store();
        test_load_ext();
        test_back_to_back();
        test_wrap_rsvd();
        test_reset_mid();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the ktc32 core, sitting directly upstream of the byte-addressed data RAM. It accepts one memory request at a time from the execute stage and drives the RAM's 16-bit write port and combinational 32-bit read port. It splits 32-bit stores into two halfword writes and merges byte stores with the neighbouring RAM byte. It returns sign- or zero-extended load data with a one-cycle response pulse.

## Interface
- ADDR_W, 16, byte address width (matches RAM address)
- DATA_W, 32, core data width; RAM write port is DATA_W/2 wide
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  load result; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; request rejected
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM byte address
- ram_wd  out  DATA_W/2  RAM write data, {byte addr+1, byte addr}
- ram_data  in  DATA_W  RAM combinational read, {addr+3..addr}

## Operation
- FSM states: IDLE, ST_HI, RESP. Reset state IDLE.
- req_ready = (state == IDLE). Accept = req_valid && req_ready.
- IDLE: ram_addr = req_addr combinationally. ram_we = accept && req_we && size valid && not rejected.
- Byte store: ram_wd = {ram_data[15:8], req_wdata[7:0]}, which preserves the byte at addr+1. Next state RESP.
- Halfword store: ram_wd = req_wdata[15:0]. Next state RESP.
- Word store: the IDLE cycle writes req_wdata[15:0] at req_addr. Address and data are latched. ST_HI writes wdata_q[31:16] at addr_q+2. Next state RESP.
- Load: ram_data is sampled at the accept edge. Byte uses [7:0] and halfword uses [15:0], each extended per req_signed. Word uses all 32 bits. The result is registered into resp_rdata. Next state RESP.
- Reserved size (11): no write, resp_err=1, resp_rdata=0. Next state RESP.
- RESP: resp_valid=1 for exactly this cycle. There is no backpressure. Next state IDLE.
- Address arithmetic (addr+2) is modulo 2^ADDR_W: 0xFFFE+2 wraps to 0x0000.
- Outside IDLE, ram_addr is driven from addr_q (ST_HI: addr_q+2). In RESP, ram_we=0.

## Timing
- Load, byte/halfword store, error: accept at edge N, resp_valid during cycle N+1. Next accept possible at edge N+2.
- Word store: accept at N, upper write during cycle N+1, resp_valid during cycle N+2.
- Back-to-back requests sustain one per 2 cycles (word stores: one per 3).
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0. ram_we is forced 0 in any cycle where rst=1. req_ready=0 while rst=1 and 1 in the first cycle after reset.
- Reset mid-operation: rst in ST_HI suppresses the upper-half write, returns to IDLE, and generates no response. rst in RESP suppresses resp_valid.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠00, is rejected.
  - Rejection means no RAM write, resp_err=1, resp_rdata=0 after the normal latency.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misaligned accesses are performed as-is, since the RAM is byte-addressed.
  - resp_err asserts only for the reserved size.

## Structure
- lsu_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - the state enum (IDLE, ST_HI, RESP);
  - the ADDR_W/DATA_W defaults.
- One combinational sub-module, lsu_load_ext, takes ram_data, size and signed, and produces the extended 32-bit load value.

## Test plan
- Byte-store merge:
  - Stimulus: RAM[0x10..0x13]=11 22 33 44, store byte 0xAB at 0x10.
  - Response: ram_wd=0x22AB, RAM reads 0x443322AB, resp_valid at N+1.
- Word store:
  - Stimulus: store 0xDEADBEEF at 0x20.
  - Response: cycle N writes 0xBEEF@0x20, cycle N+1 writes 0xDEAD@0x22, resp_valid at N+2, load word returns 0xDEADBEEF.
- Load extension:
  - Stimulus: RAM[0x30..]=0x80 0xFF; load byte signed, byte unsigned, half signed.
  - Response: 0xFFFFFF80, 0x00000080, 0xFFFFFF80.
- Wrap and reserved size:
  - Stimulus: word store at 0xFFFE; then a request with size 11.
  - Response: the word store writes the upper half at 0x0000; the size-11 request gives resp_err=1 with ram_we never asserted.
- Reset mid-store:
  - Stimulus: assert rst during ST_HI of a word store.
  - Response: only the lower half is written, no resp_valid, req_ready=1 after rst is released.
- Misaligned access:
  - Stimulus: halfword store at 0x41.
  - Response with LSU_MISALIGN_TRAP_EN: resp_err=1 and no write.
  - Response without it: the write lands at 0x41/0x42 and resp_err=0.
